// File: rtl/cas_recorder.sv
// -----------------------------------------------------------------------------
// cas_recorder
// Tape-save path. Demodulates the 6-bit cassette DAC output into FSK bits and
// then into bytes. Each recognised block is written to SDRAM as a .CAS image
// with a regenerated leader (LEAD_BYTES x 8'h55) and a single 8'h3C sync byte,
// followed by the block's data bytes.
//
// Ports
//   clk_i        system clock
//   reset_i      asynchronous reset, active low
//   q_ce_i       one-clock pulse per CPU Q cycle (period time base)
//   en_i         cassette relay, record gate
//   rewind_i     level; clears address/length/overflow and forces idle
//   sound_i[5:0] DAC output level
//   wr_req_o     SDRAM write request, held until wr_ack_i
//   wr_addr_o    write byte address
//   wr_data_o    write byte
//   wr_ack_i     one-clock accept pulse from SDRAM
//   length_o     number of bytes written so far
//   recording_o  byte assembler is locked inside a block
//   overflow_o   sticky; a byte was dropped (FIFO full or address limit)
// -----------------------------------------------------------------------------
module cas_recorder #(
    parameter int          MID         = 32,
    parameter int          HYST        = 4,
    parameter int          MIN_TICKS   = 200,
    parameter int          THRESH      = 560,
    parameter int          GAP_TICKS   = 2000,
    parameter int          LEADER_BITS = 64,
    parameter int          LEAD_BYTES  = 128,
    parameter logic [24:0] ADDR_LIMIT  = 25'h1FFFFFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        q_ce_i,
    input  logic        en_i,
    input  logic        rewind_i,
    input  logic [5:0]  sound_i,
    output logic        wr_req_o,
    output logic [24:0] wr_addr_o,
    output logic [7:0]  wr_data_o,
    input  logic        wr_ack_i,
    output logic [24:0] length_o,
    output logic        recording_o,
    output logic        overflow_o
);

    localparam logic [6:0]  HI_TH     = 7'(MID + HYST);
    localparam logic [6:0]  LO_TH     = 7'(MID - HYST);
    localparam logic [11:0] MIN_T     = 12'(MIN_TICKS);
    localparam logic [11:0] THR_T     = 12'(THRESH);
    localparam logic [11:0] GAP_T     = 12'(GAP_TICKS);
    localparam logic [7:0]  LEAD_THR  = 8'(LEADER_BITS);
    localparam logic [15:0] LEAD_LAST = 16'(LEAD_BYTES - 1);

    typedef enum logic {A_HUNT = 1'b0, A_LOCKED = 1'b1} asm_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_LEAD = 2'd1, W_SYNC = 2'd2, W_DATA = 2'd3} wr_state_t;

    // ---------------- front end: level, period, gap ----------------
    logic        level_q, level_d;
    logic [11:0] period_q, period_d;
    logic        gap_q, gap_d;
    logic        crossing_s, gap_now_s, bit_valid_s, bit_val_s;

    // Hysteresis slicer, period counter and bit decision.
    always_comb begin
        level_d     = level_q;
        period_d    = period_q;
        gap_d       = gap_q;
        bit_valid_s = 1'b0;
        bit_val_s   = 1'b0;
        if ({1'b0, sound_i} >= HI_TH) begin
            level_d = 1'b1;
        end else if ({1'b0, sound_i} <= LO_TH) begin
            level_d = 1'b0;
        end else begin
            level_d = level_q;
        end
        crossing_s = level_d & ~level_q;
        // The gap may be reached on the same clock as a crossing; that crossing
        // must still be treated as the first one after the gap.
        gap_now_s  = gap_q | (period_q >= GAP_T);
        if (!en_i) begin
            period_d = 12'd0;
            gap_d    = 1'b1;
        end else begin
            if (q_ce_i && (period_q != 12'hFFF)) begin
                period_d = period_q + 12'd1;
            end else begin
                period_d = period_q;
            end
            if (period_q >= GAP_T) begin
                gap_d = 1'b1;
            end else begin
                gap_d = gap_q;
            end
            // Crossings closer than MIN_T are glitches; the counter keeps running.
            if (crossing_s && (period_q >= MIN_T)) begin
                bit_valid_s = ~gap_now_s;
                bit_val_s   = (period_q < THR_T);
                period_d    = 12'd0;
                gap_d       = 1'b0;
            end else begin
                bit_valid_s = 1'b0;
            end
        end
    end

    // Front-end state registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            level_q  <= 1'b0;
            period_q <= 12'd0;
            gap_q    <= 1'b1;
        end else if (rewind_i) begin
            level_q  <= 1'b0;
            period_q <= 12'd0;
            gap_q    <= 1'b1;
        end else begin
            level_q  <= level_d;
            period_q <= period_d;
            gap_q    <= gap_d;
        end
    end

    // ---------------- byte assembler ----------------
    asm_state_t  asm_q, asm_d;
    logic [7:0]  window_q, window_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  alt_q, alt_d;
    logic        leader_ok_q, leader_ok_d;
    logic        prev_bit_q, prev_bit_d;
    logic        lead_start_s, push_s;

    // Leader/sync hunt and LSB-first byte framing.
    always_comb begin
        asm_d        = asm_q;
        window_d     = window_q;
        bitcnt_d     = bitcnt_q;
        alt_d        = alt_q;
        leader_ok_d  = leader_ok_q;
        prev_bit_d   = prev_bit_q;
        lead_start_s = 1'b0;
        push_s       = 1'b0;
        if (gap_q) begin
            // Silence or relay off ends the block; a fresh leader is required.
            asm_d       = A_HUNT;
            alt_d       = 8'd0;
            leader_ok_d = 1'b0;
            bitcnt_d    = 3'd0;
        end else if (bit_valid_s) begin
            window_d   = {bit_val_s, window_q[7:1]};
            prev_bit_d = bit_val_s;
            case (asm_q)
                A_HUNT: begin
                    if (bit_val_s != prev_bit_q) begin
                        alt_d = (alt_q == 8'hFF) ? alt_q : alt_q + 8'd1;
                    end else begin
                        alt_d = 8'd0;
                    end
                    if (alt_d >= LEAD_THR) begin
                        leader_ok_d = 1'b1;
                    end else begin
                        leader_ok_d = leader_ok_q;
                    end
                    if ((window_d == 8'h3C) && leader_ok_q) begin
                        asm_d        = A_LOCKED;
                        lead_start_s = 1'b1;
                        bitcnt_d     = 3'd0;
                        leader_ok_d  = 1'b0;
                        alt_d        = 8'd0;
                    end else begin
                        asm_d = A_HUNT;
                    end
                end
                A_LOCKED: begin
                    if (bitcnt_q == 3'd7) begin
                        push_s   = 1'b1;
                        bitcnt_d = 3'd0;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
                default: begin
                    asm_d = A_HUNT;
                end
            endcase
        end else begin
            asm_d = asm_q;
        end
    end

    // Assembler state registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            asm_q       <= A_HUNT;
            window_q    <= 8'd0;
            bitcnt_q    <= 3'd0;
            alt_q       <= 8'd0;
            leader_ok_q <= 1'b0;
            prev_bit_q  <= 1'b0;
        end else if (rewind_i) begin
            asm_q       <= A_HUNT;
            window_q    <= 8'd0;
            bitcnt_q    <= 3'd0;
            alt_q       <= 8'd0;
            leader_ok_q <= 1'b0;
            prev_bit_q  <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            window_q    <= window_d;
            bitcnt_q    <= bitcnt_d;
            alt_q       <= alt_d;
            leader_ok_q <= leader_ok_d;
            prev_bit_q  <= prev_bit_d;
        end
    end

    // ---------------- 4-entry byte FIFO ----------------
    logic [7:0] fifo_mem_q [4];
    logic [1:0] wptr_q, rptr_q;
    logic [2:0] cnt_q;
    logic       pop_s, push_ok_s, drop_s;

    assign push_ok_s = push_s && (cnt_q != 3'd4);
    assign drop_s    = push_s && (cnt_q == 3'd4);

    // FIFO storage and pointers; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 4; i++) fifo_mem_q[i] <= 8'd0;
            wptr_q <= 2'd0;
            rptr_q <= 2'd0;
            cnt_q  <= 3'd0;
        end else if (rewind_i) begin
            wptr_q <= 2'd0;
            rptr_q <= 2'd0;
            cnt_q  <= 3'd0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_q[wptr_q] <= window_d;
                wptr_q             <= wptr_q + 2'd1;
            end
            if (pop_s) begin
                rptr_q <= rptr_q + 2'd1;
            end
            cnt_q <= cnt_q + {2'd0, push_ok_s} - {2'd0, pop_s};
        end
    end

    // ---------------- writer ----------------
    wr_state_t   wst_q, wst_d;
    logic        wr_req_q, wr_req_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic [25:0] addr_q, addr_d;
    logic [24:0] len_q, len_d;
    logic [15:0] lead_cnt_q, lead_cnt_d;
    logic        lead_pend_q, lead_pend_d;
    logic        ovf_q, ovf_d;
    logic        have_byte_s, done_s, discard_s;
    logic [7:0]  byte_s;

    // Writer FSM and SDRAM handshake.
    always_comb begin
        wst_d       = wst_q;
        wr_req_d    = wr_req_q;
        wr_data_d   = wr_data_q;
        addr_d      = addr_q;
        len_d       = len_q;
        lead_cnt_d  = lead_cnt_q;
        lead_pend_d = lead_pend_q | lead_start_s;
        pop_s       = 1'b0;
        done_s      = 1'b0;
        discard_s   = 1'b0;
        case (wst_q)
            W_LEAD: begin
                have_byte_s = 1'b1;
                byte_s      = 8'h55;
            end
            W_SYNC: begin
                have_byte_s = 1'b1;
                byte_s      = 8'h3C;
            end
            W_DATA: begin
                have_byte_s = (cnt_q != 3'd0);
                byte_s      = fifo_mem_q[rptr_q];
            end
            default: begin
                have_byte_s = 1'b0;
                byte_s      = 8'h00;
            end
        endcase
        // The request is registered, so it is always low for at least one
        // clock after an ack before the next byte can be offered.
        if (wr_req_q) begin
            if (wr_ack_i) begin
                wr_req_d = 1'b0;
                addr_d   = addr_q + 26'd1;
                len_d    = (len_q == 25'h1FFFFFF) ? len_q : len_q + 25'd1;
                done_s   = 1'b1;
            end else begin
                wr_req_d = 1'b1;
            end
        end else if (have_byte_s) begin
            if (addr_q <= {1'b0, ADDR_LIMIT}) begin
                wr_req_d  = 1'b1;
                wr_data_d = byte_s;
            end else begin
                discard_s = 1'b1;
                done_s    = 1'b1;
            end
        end else begin
            wr_req_d = 1'b0;
        end
        case (wst_q)
            W_IDLE: begin
                if (lead_pend_q) begin
                    wst_d       = W_LEAD;
                    lead_cnt_d  = 16'd0;
                    lead_pend_d = lead_start_s;
                end else begin
                    wst_d = W_IDLE;
                end
            end
            W_LEAD: begin
                if (done_s) begin
                    if (lead_cnt_q == LEAD_LAST) begin
                        wst_d = W_SYNC;
                    end else begin
                        lead_cnt_d = lead_cnt_q + 16'd1;
                    end
                end else begin
                    wst_d = W_LEAD;
                end
            end
            W_SYNC: begin
                if (done_s) begin
                    wst_d = W_DATA;
                end else begin
                    wst_d = W_SYNC;
                end
            end
            W_DATA: begin
                if (done_s) begin
                    pop_s = 1'b1;
                end else if (!wr_req_q && (cnt_q == 3'd0)) begin
                    // A new block's leader waits until the old data is drained.
                    if (lead_pend_q) begin
                        wst_d       = W_LEAD;
                        lead_cnt_d  = 16'd0;
                        lead_pend_d = lead_start_s;
                    end else if (asm_q == A_HUNT) begin
                        wst_d = W_IDLE;
                    end else begin
                        wst_d = W_DATA;
                    end
                end else begin
                    wst_d = W_DATA;
                end
            end
            default: begin
                wst_d = W_IDLE;
            end
        endcase
        ovf_d = ovf_q | drop_s | discard_s;
    end

    // Writer state registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wst_q       <= W_IDLE;
            wr_req_q    <= 1'b0;
            wr_data_q   <= 8'd0;
            addr_q      <= 26'd0;
            len_q       <= 25'd0;
            lead_cnt_q  <= 16'd0;
            lead_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (rewind_i) begin
            wst_q       <= W_IDLE;
            wr_req_q    <= 1'b0;
            wr_data_q   <= 8'd0;
            addr_q      <= 26'd0;
            len_q       <= 25'd0;
            lead_cnt_q  <= 16'd0;
            lead_pend_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            wst_q       <= wst_d;
            wr_req_q    <= wr_req_d;
            wr_data_q   <= wr_data_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            lead_cnt_q  <= lead_cnt_d;
            lead_pend_q <= lead_pend_d;
            ovf_q       <= ovf_d;
        end
    end

    assign wr_req_o    = wr_req_q;
    assign wr_addr_o   = addr_q[24:0];
    assign wr_data_o   = wr_data_q;
    assign length_o    = len_q;
    assign recording_o = (asm_q == A_LOCKED);
    assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cas_recorder.sv
module tb_cas_recorder;

    // Time base scaled by 1/10 with q_ce every clock to keep runs short.
    localparam int LEADN = 128;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        q_ce = 1'b1;
    logic        en = 1'b0;
    logic        rewind = 1'b0;
    logic [5:0]  sound = 6'd0;
    logic        wr_req;
    logic [24:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [24:0] length;
    logic        recording;
    logic        overflow;

    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        hold = 1'b0;
    logic [24:0] got_addr[$];
    logic [7:0]  got_data[$];
    logic [7:0]  exp_data[$];
    logic [7:0]  cur[$];

    int n_pass = 0;
    int n_total = 0;

    assign wr_ack = resp_ack | stray_ack;

    always #5 clk = ~clk;

    cas_recorder #(
        .MID(32), .HYST(4), .MIN_TICKS(20), .THRESH(56), .GAP_TICKS(200),
        .LEADER_BITS(64), .LEAD_BYTES(LEADN), .ADDR_LIMIT(25'h1FFFFFF)
    ) dut (
        .clk_i(clk), .reset_i(reset_n), .q_ce_i(q_ce), .en_i(en), .rewind_i(rewind),
        .sound_i(sound), .wr_req_o(wr_req), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .wr_ack_i(wr_ack), .length_o(length), .recording_o(recording), .overflow_o(overflow)
    );

    // SDRAM model: random ack latency, one-clock pulses, logs accepted writes.
    always @(negedge clk) begin
        if (resp_ack) begin
            resp_ack = 1'b0;
        end else if (wr_req && !hold && ($urandom_range(1, 0) == 1)) begin
            resp_ack = 1'b1;
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one level segment: strong level first, then a value inside the hysteresis band.
    task automatic seg(input bit hi, input int n);
        sound = hi ? 6'($urandom_range(63, 36)) : 6'($urandom_range(28, 0));
        if (n <= 2) begin
            clks(n);
        end else begin
            clks(2);
            sound = 6'($urandom_range(35, 29));
            clks(n - 2);
        end
    endtask

    // One FSK cycle; its bit is decided by the rising crossing that ends it.
    task automatic cyc(input bit b, input bit gl);
        int p;
        p = b ? int'($urandom_range(45, 30)) : int'($urandom_range(90, 62));
        if (gl && !b) begin
            seg(1'b1, 7); seg(1'b0, 8); seg(1'b1, 25); seg(1'b0, p - 40);
        end else begin
            seg(1'b1, p / 2); seg(1'b0, p - p / 2);
        end
    endtask

    task automatic leader(input int n);
        for (int i = 0; i < n; i++) cyc((i % 2) == 0, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit glitchy);
        for (int i = 0; i < 8; i++) cyc(b[i], glitchy & ($urandom_range(1, 0) == 1));
    endtask

    task automatic trail();
        seg(1'b1, 10);
        sound = 6'($urandom_range(28, 0));
    endtask

    task automatic idle(input int n);
        sound = 6'($urandom_range(28, 0));
        clks(n);
    endtask

    // Expected image of one block: regenerated leader, sync, then the data in cur.
    task automatic add_block();
        for (int i = 0; i < LEADN; i++) exp_data.push_back(8'h55);
        exp_data.push_back(8'h3C);
        foreach (cur[i]) exp_data.push_back(cur[i]);
    endtask

    task automatic send_block(input bit glitchy);
        leader(80);
        send_byte(8'h3C, 1'b0);
        foreach (cur[i]) send_byte(cur[i], glitchy);
        trail();
    endtask

    task automatic wait_writes(input string tag, input int n);
        int t;
        t = 0;
        while ((got_data.size() < n) && (t < 6000)) begin
            clks(1);
            t++;
        end
        clks(20);
        chk(tag, got_data.size(), n);
    endtask

    task automatic check_image(input string tag);
        int nbad;
        nbad = 0;
        for (int i = 0; i < exp_data.size(); i++) begin
            if ((i >= got_data.size()) || (got_addr[i] != 25'(i)) || (got_data[i] != exp_data[i])) nbad++;
        end
        chk(tag, nbad, 0);
    endtask

    task automatic clear_logs();
        got_addr.delete();
        got_data.delete();
        exp_data.delete();
        cur.delete();
    endtask

    initial begin
        int t;
        // Reset state
        clks(5);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_length", length, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_recording", recording, 0);
        chk("rst_addr", wr_addr, 0);
        reset_n = 1'b1;
        en = 1'b1;
        idle(260);

        // Basic block, with glitched zero bits inside the 0x12 byte
        cur.push_back(8'h12);
        add_block();
        leader(80);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h12, 1'b1);
        trail();
        chk("t2_recording_on", recording, 1);
        idle(260);
        chk("t2_recording_off", recording, 0);
        wait_writes("t2_count", 130);
        check_image("t2_image");
        chk("t2_length", length, 130);
        chk("t2_overflow", overflow, 0);

        // Short leader: sync must not be accepted
        leader(40);
        send_byte(8'h3C, 1'b0);
        trail();
        chk("t4_recording", recording, 0);
        idle(300);
        chk("t4_no_writes", got_data.size(), 130);
        chk("t4_length", length, 130);

        // Asynchronous reset in the middle of a leader write-out
        clear_logs();
        hold = 1'b1;
        cur.push_back(8'hA7);
        send_block(1'b0);
        t = 0;
        while (!wr_req && (t < 500)) begin clks(1); t++; end
        chk("t1_req_before", wr_req, 1);
        chk("t1_rec_before", recording, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("t1_req_async", wr_req, 0);
        chk("t1_len_async", length, 0);
        chk("t1_ovf_async", overflow, 0);
        chk("t1_rec_async", recording, 0);
        clks(3);
        reset_n = 1'b1;
        clear_logs();
        hold = 1'b0;
        idle(260);
        chk("t1_addr_after", wr_addr, 0);
        chk("t1_no_writes", got_data.size(), 0);
        chk("t1_rec_after", recording, 0);

        // Rewind during an outstanding request; late ack must be ignored
        hold = 1'b1;
        cur.push_back(8'h01);
        send_block(1'b0);
        t = 0;
        while (!wr_req && (t < 500)) begin clks(1); t++; end
        chk("rw_req_before", wr_req, 1);
        rewind = 1'b1;
        @(posedge clk);
        #1;
        chk("rw_req_dropped", wr_req, 0);
        @(negedge clk);
        rewind = 1'b0;
        stray_ack = 1'b1;
        clks(1);
        stray_ack = 1'b0;
        clks(5);
        chk("rw_length", length, 0);
        chk("rw_addr", wr_addr, 0);
        chk("rw_recording", recording, 0);
        chk("rw_req_idle", wr_req, 0);
        hold = 1'b0;
        idle(260);

        // Ack withheld during leader while five data bytes arrive
        clear_logs();
        hold = 1'b1;
        for (int i = 0; i < 5; i++) cur.push_back(8'($urandom_range(255, 0)));
        send_block(1'b0);
        chk("t5_req_held", wr_req, 1);
        chk("t5_addr_held", wr_addr, 0);
        chk("t5_overflow", overflow, (cur.size() > 4) ? 1 : 0);
        idle(3000);
        cur.delete(4);
        add_block();
        hold = 1'b0;
        wait_writes("t5_count", exp_data.size());
        check_image("t5_image");
        chk("t5_length", length, exp_data.size());
        chk("t5_overflow_sticky", overflow, 1);

        // Two blocks separated by a gap; second is appended
        rewind = 1'b1;
        clks(2);
        rewind = 1'b0;
        clear_logs();
        chk("t6_ovf_cleared", overflow, 0);
        for (int i = 0; i < 2; i++) cur.push_back(8'($urandom_range(255, 0)));
        add_block();
        send_block(1'b1);
        chk("t6_rec_a", recording, 1);
        idle(210 + 50);
        chk("t6_rec_gap", recording, 0);
        cur.delete();
        cur.push_back(8'($urandom_range(255, 0)));
        add_block();
        send_block(1'b1);
        chk("t6_rec_b", recording, 1);
        idle(260);
        wait_writes("t6_count", exp_data.size());
        check_image("t6_image");
        chk("t6_length", length, exp_data.size());
        chk("t6_overflow", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
